// File: rtl/fp_arb_pkg.sv
// Shared types and widths for the floating-point adder arbiter.
// Sequencer states, datapath, watchdog and counter widths.
package fp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam int FP_W   = 32;
  localparam int WDOG_W = 8;
  localparam int CNT_W  = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search starting one past last_gnt.
// Lowest distance from the pointer wins.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_gnt,
  output logic [$clog2(N)-1:0] gnt,
  output logic                 any
);

  localparam int IW = $clog2(N);
  localparam logic [IW:0] NV = (IW+1)'(N);

  logic [IW:0] pos;

  // Walk from farthest to nearest so the nearest hit is kept.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    pos = '0;
    for (int k = N; k >= 1; k--) begin
      pos = {1'b0, last_gnt} + (IW+1)'(k);
      if (pos >= NV) begin
        pos = pos - NV;
      end
      if (req[pos[IW-1:0]]) begin
        gnt = pos[IW-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one FP adder among N_REQ requesters: round-robin grant,
// load/ack handshake, result routing and a WAIT watchdog.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = FP_W,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic                    add_load,
  output logic [DATA_W-1:0]       add_a,
  output logic [DATA_W-1:0]       add_b,
  input  logic [DATA_W-1:0]       add_result,
  input  logic                    add_ready,
  output logic                    add_ack,
  output logic [CNT_W-1:0]        op_count
);

  localparam int IW = $clog2(N_REQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]     last_gnt_q, last_gnt_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [IW-1:0]     arb_gnt;
  logic              arb_any;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [N_REQ-1:0]  gnt_oh;
  logic              wdog_hit;

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .req     (req_valid),
    .last_gnt(last_gnt_q),
    .gnt     (arb_gnt),
    .any     (arb_any)
  );

  assign sel_a    = req_a[int'(gnt_q)*DATA_W +: DATA_W];
  assign sel_b    = req_b[int'(gnt_q)*DATA_W +: DATA_W];
  assign gnt_oh   = N_REQ'(1) << gnt_q;
  assign wdog_hit = (wdog_q == WDOG_W'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_gnt_q <= IW'(N_REQ-1);
      op_a_q     <= '0;
      op_b_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      wdog_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      data_q     <= data_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    data_d     = data_q;
    err_d      = err_q;
    wdog_d     = wdog_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_gnt;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        op_a_d     = sel_a;
        op_b_d     = sel_b;
        last_gnt_d = gnt_q;
        wdog_d     = '0;
        err_d      = 1'b0;
        state_d    = WAIT;
      end
      WAIT: begin
        // A real result wins over a coincident watchdog expiry.
        if (add_ready) begin
          data_d  = add_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wdog_hit) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready[gnt_q]) begin
          state_d = IDLE;
          if (!err_q) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_err   = 1'b0;
    add_load  = 1'b0;
    add_ack   = 1'b0;
    add_a     = op_a_q;
    add_b     = op_b_q;
    unique case (state_q)
      ISSUE: begin
        add_load  = 1'b1;
        req_ready = gnt_oh;
        add_a     = sel_a;
        add_b     = sel_b;
      end
      WAIT: add_ack = add_ready | wdog_hit;
      RESP: begin
        rsp_valid = gnt_oh;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

  assign rsp_data = data_q;
  assign op_count = cnt_q;

endmodule
